// File: rtl/temp_ctrl_pkg.sv
// rtl/temp_ctrl_pkg.sv - shared types and constants for the cooling request path
//
// Purpose: FSM state type, default thresholds/hold/timeout, and the sensor
// fault codes (all-zeros and all-ones of the sample width).
// Ports: none (package).
package temp_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_OFF   = 2'd1,
    ST_ON    = 2'd2,
    ST_FAULT = 2'd3
  } temp_state_t;

  localparam int unsigned DEF_T_HIGH   = 140;
  localparam int unsigned DEF_T_LOW    = 120;
  localparam int unsigned DEF_MIN_HOLD = 1000;
  localparam int unsigned DEF_TIMEOUT  = 100000;

  // Low fault code is all-zeros at any width.
  localparam logic [63:0] FAULT_CODE_LO = 64'd0;

  // High fault code: all-ones of a w-bit sample.
  function automatic logic [63:0] fault_code_hi(input int unsigned w);
    return (64'd1 << w) - 64'd1;
  endfunction

  function automatic logic is_fault_code(input logic [63:0] v, input int unsigned w);
    return (v == FAULT_CODE_LO) || (v == fault_code_hi(w));
  endfunction

endpackage

// File: rtl/temp_avg_window.sv
// rtl/temp_avg_window.sv - moving-average window with running sum
//
// Purpose: keeps the last 2^AVG_LOG2 good samples and their running sum, and
// publishes the truncated average one cycle after each window update once the
// window is full.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   shift_en            push sample_data into the window (oldest drops out)
//   load_en             clear the window and load sample_data as first entry
//   sample_data         sample to push/load
//   avg_temp            latest full-window average
//   avg_valid           one-cycle pulse when avg_temp updates
//   full                window holds 2^AVG_LOG2 samples
module temp_avg_window
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned AVG_LOG2 = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              shift_en,
  input  logic              load_en,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] avg_temp,
  output logic              avg_valid,
  output logic              full
);

  localparam int unsigned DEPTH  = 1 << AVG_LOG2;
  localparam int unsigned SUM_W  = DATA_W + AVG_LOG2;
  localparam int unsigned FILL_W = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] win_q [DEPTH];
  logic [SUM_W-1:0]  sum_q;
  logic [FILL_W-1:0] fill_q;
  logic              upd_q;

  assign full = (fill_q == FILL_W'(DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      upd_q     <= 1'b0;
      avg_temp  <= '0;
      avg_valid <= 1'b0;
    end else begin
      // The average register trails the sum by one cycle.
      upd_q     <= shift_en | load_en;
      avg_valid <= upd_q & full;
      if (upd_q && full) avg_temp <= DATA_W'(sum_q >> AVG_LOG2);

      if (load_en) begin
        win_q[0] <= sample_data;
        for (int i = 1; i < DEPTH; i++) win_q[i] <= '0;
        sum_q  <= SUM_W'(sample_data);
        fill_q <= FILL_W'(1);
      end else if (shift_en) begin
        win_q[0] <= sample_data;
        for (int i = 1; i < DEPTH; i++) win_q[i] <= win_q[i-1];
        // Unfilled slots are zero, so subtracting the oldest is safe while filling.
        sum_q <= sum_q + SUM_W'(sample_data) - SUM_W'(win_q[DEPTH-1]);
        if (!full) fill_q <= fill_q + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/temp_cool_request.sv
// rtl/temp_cool_request.sv - temperature conditioning and cooling request
//
// Purpose: accepts raw temperature samples, averages them, and drives cool_req
// with hysteresis, minimum hold time between changes, and sensor-fault /
// timeout detection.
// Ports:
//   sync_clk, reset_n   clock, asynchronous active-low reset
//   sample_valid        sample present on sample_data
//   sample_data         raw temperature code
//   sample_ready        block can accept a sample (low only in reset)
//   avg_temp            latest window average
//   avg_valid           one-cycle pulse when avg_temp updates
//   cool_req            cooling request
//   fault               sensor fault active
module temp_cool_request
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned       DATA_W   = 8,
  parameter int unsigned       AVG_LOG2 = 2,
  parameter logic [DATA_W-1:0] T_HIGH   = DATA_W'(DEF_T_HIGH),
  parameter logic [DATA_W-1:0] T_LOW    = DATA_W'(DEF_T_LOW),
  parameter int unsigned       MIN_HOLD = DEF_MIN_HOLD,
  parameter int unsigned       TIMEOUT  = DEF_TIMEOUT
) (
  input  logic              sync_clk,
  input  logic              reset_n,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_data,
  output logic              sample_ready,
  output logic [DATA_W-1:0] avg_temp,
  output logic              avg_valid,
  output logic              cool_req,
  output logic              fault
);

  localparam int unsigned HOLD_W = $clog2(MIN_HOLD + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
  localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);

  temp_state_t       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]   to_q, to_d;

  logic accept;
  logic bad_sample;
  logic good_sample;
  logic win_shift;
  logic win_load;
  logic win_full;
  logic hold_done;
  logic to_expire;

  // Ready is simply "out of reset"; the block never back-pressures.
  assign sample_ready = reset_n;
  assign accept       = sample_valid & sample_ready;
  assign bad_sample   = accept & is_fault_code(64'(sample_data), DATA_W);
  assign good_sample  = accept & ~bad_sample;
  assign win_load     = good_sample & (state_q == ST_FAULT);
  assign win_shift    = good_sample & (state_q != ST_FAULT);
  assign hold_done    = (hold_q == HOLD_MAX);

  temp_avg_window #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_window (
    .clk         (sync_clk),
    .reset_n     (reset_n),
    .shift_en    (win_shift),
    .load_en     (win_load),
    .sample_data (sample_data),
    .avg_temp    (avg_temp),
    .avg_valid   (avg_valid),
    .full        (win_full)
  );

  // An accept on the expiry edge clears the counter, so it never expires then.
  always_comb begin
    to_d = to_q;
    if (accept)              to_d = '0;
    else if (to_q != TO_MAX) to_d = to_q + TO_W'(1);
  end

  assign to_expire = ~accept & (to_d == TO_MAX);

  always_comb begin
    state_d = state_q;
    if (bad_sample || to_expire) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_FILL:  if (win_full) state_d = ST_OFF;
        ST_OFF:   if ((avg_temp > T_HIGH) && hold_done) state_d = ST_ON;
        ST_ON:    if ((avg_temp < T_LOW) && hold_done) state_d = ST_OFF;
        ST_FAULT: if (good_sample) state_d = ST_FILL;
        default:  state_d = ST_FILL;
      endcase
    end
  end

  // Hold restarts on each cool_req edge; leaving FILL starts it expired so the
  // first decision after a (re)fill is not delayed.
  always_comb begin
    hold_d = hold_q;
    if ((state_d == ST_ON) != (state_q == ST_ON))
      hold_d = '0;
    else if ((state_q == ST_FILL) && (state_d != ST_FILL))
      hold_d = HOLD_MAX;
    else if (!hold_done)
      hold_d = hold_q + HOLD_W'(1);
  end

  always_ff @(posedge sync_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FILL;
      hold_q  <= '0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end

  assign cool_req = (state_q == ST_ON);
  assign fault    = (state_q == ST_FAULT);

endmodule

// File: tb/tb_temp_cool_request.sv
// tb/tb_temp_cool_request.sv - self-checking bench for temp_cool_request
module tb_temp_cool_request;

  localparam int DW       = 8;
  localparam int NWIN     = 4;
  localparam int MAXCODE  = 255;
  localparam int TH       = 140;
  localparam int TL       = 120;
  localparam int MIN_HOLD = 60;
  localparam int TIMEOUT  = 250;

  localparam int M_FILL  = 0;
  localparam int M_OFF   = 1;
  localparam int M_ON    = 2;
  localparam int M_FAULT = 3;

  logic          clk;
  logic          reset_n;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          sample_ready;
  logic [DW-1:0] avg_temp;
  logic          avg_valid;
  logic          cool_req;
  logic          fault;

  temp_cool_request #(
    .DATA_W   (DW),
    .AVG_LOG2 (2),
    .T_HIGH   (8'(TH)),
    .T_LOW    (8'(TL)),
    .MIN_HOLD (MIN_HOLD),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .sync_clk     (clk),
    .reset_n      (reset_n),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ready (sample_ready),
    .avg_temp     (avg_temp),
    .avg_valid    (avg_valid),
    .cool_req     (cool_req),
    .fault        (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int pulses = 0;
  int seen[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: last NWIN good samples as a queue, average as plain division.
  int q[$];
  int m_avg;
  int m_avg_valid;
  int pend;
  int m_mode;
  int m_hold;
  int m_idle;

  task automatic model_reset();
    q.delete();
    m_avg = 0;
    m_avg_valid = 0;
    pend = 0;
    m_mode = M_FILL;
    m_hold = 0;
    m_idle = 0;
  endtask

  task automatic model_step(input bit v, input int d);
    bit bad, good;
    int n_mode, n_idle, s;
    bad  = v && (d == 0 || d == MAXCODE);
    good = v && !bad;
    n_idle = v ? 0 : ((m_idle + 1 > TIMEOUT) ? TIMEOUT : m_idle + 1);
    n_mode = m_mode;
    if (bad || (!v && n_idle == TIMEOUT)) n_mode = M_FAULT;
    else if (m_mode == M_FILL && q.size() == NWIN) n_mode = M_OFF;
    else if (m_mode == M_OFF && m_avg > TH && m_hold == MIN_HOLD) n_mode = M_ON;
    else if (m_mode == M_ON && m_avg < TL && m_hold == MIN_HOLD) n_mode = M_OFF;
    else if (m_mode == M_FAULT && good) n_mode = M_FILL;

    if ((n_mode == M_ON) != (m_mode == M_ON)) m_hold = 0;
    else if (m_mode == M_FILL && n_mode != M_FILL) m_hold = MIN_HOLD;
    else if (m_hold < MIN_HOLD) m_hold++;

    m_avg_valid = (pend != 0 && q.size() == NWIN) ? 1 : 0;
    if (m_avg_valid != 0) begin
      s = 0;
      foreach (q[i]) s += q[i];
      m_avg = s / NWIN;
    end

    if (good) begin
      if (m_mode == M_FAULT) q.delete();
      q.push_front(d);
      if (q.size() > NWIN) void'(q.pop_back());
    end
    pend   = good ? 1 : 0;
    m_mode = n_mode;
    m_idle = n_idle;
  endtask

  task automatic cycle(input bit v, input int d);
    sample_valid = v;
    sample_data  = 8'(d);
    model_step(v, d);
    @(posedge clk);
    #1;
    check_eq("sample_ready", 32'(sample_ready), 1);
    check_eq("avg_temp", 32'(avg_temp), m_avg);
    check_eq("avg_valid", 32'(avg_valid), m_avg_valid);
    check_eq("cool_req", 32'(cool_req), (m_mode == M_ON) ? 1 : 0);
    check_eq("fault", 32'(fault), (m_mode == M_FAULT) ? 1 : 0);
    if (avg_valid) begin
      pulses++;
      seen.push_back(int'(avg_temp));
    end
  endtask

  task automatic do_reset();
    #2;
    reset_n = 1'b0;
    sample_valid = 1'b0;
    #1;
    check_eq("rst_cool_req", 32'(cool_req), 0);
    check_eq("rst_fault", 32'(fault), 0);
    check_eq("rst_avg_temp", 32'(avg_temp), 0);
    check_eq("rst_avg_valid", 32'(avg_valid), 0);
    check_eq("rst_sample_ready", 32'(sample_ready), 0);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int ramp_exp[4] = '{115, 130, 145, 160};
  int r, p, d, base;
  bit v;

  initial begin
    reset_n = 1'b1;
    sample_valid = 1'b0;
    sample_data = '0;
    model_reset();
    do_reset();

    // Fill at 100.
    pulses = 0;
    repeat (4) cycle(1, 100);
    cycle(0, 0);
    check_eq("fill_pulses", pulses, 1);
    check_eq("fill_avg", 32'(avg_temp), 100);
    check_eq("fill_cool", 32'(cool_req), 0);

    // Ramp to 160; rise two edges after the accept that yields 145.
    seen.delete();
    repeat (3) cycle(1, 160);
    check_eq("cool_k3", 32'(cool_req), 0);
    cycle(1, 160);
    check_eq("cool_k3p1", 32'(cool_req), 0);
    cycle(1, 100);
    check_eq("cool_rise", 32'(cool_req), 1);
    check_eq("ramp_count", seen.size(), 4);
    for (int i = 0; i < 4 && i < seen.size(); i++) check_eq("ramp_avg", seen[i], ramp_exp[i]);

    // Falls only after the hold expires.
    repeat (3) cycle(1, 100);
    repeat (MIN_HOLD - 3) cycle(0, 0);
    check_eq("hold_keep", 32'(cool_req), 1);
    cycle(0, 0);
    check_eq("hold_fall", 32'(cool_req), 0);

    // Back on, then a fault code.
    repeat (4) cycle(1, 200);
    repeat (MIN_HOLD + 2) cycle(0, 0);
    check_eq("reon", 32'(cool_req), 1);
    cycle(1, MAXCODE);
    check_eq("ff_fault", 32'(fault), 1);
    check_eq("ff_cool", 32'(cool_req), 0);
    cycle(1, MAXCODE);
    check_eq("fault_stay", 32'(fault), 1);
    pulses = 0;
    cycle(1, 100);
    check_eq("fault_exit", 32'(fault), 0);
    cycle(1, 100);
    cycle(1, 100);
    cycle(0, 0);
    check_eq("refill_nopulse", pulses, 0);
    cycle(1, 100);
    cycle(0, 0);
    check_eq("refill_pulse", pulses, 1);
    check_eq("refill_avg", 32'(avg_temp), 100);

    // Reset while ON.
    repeat (4) cycle(1, 200);
    repeat (4) cycle(0, 0);
    check_eq("on_before_reset", 32'(cool_req), 1);
    do_reset();

    // Timeout, and accept on the expiry edge.
    repeat (TIMEOUT - 1) cycle(0, 0);
    check_eq("to_before", 32'(fault), 0);
    cycle(0, 0);
    check_eq("to_hit", 32'(fault), 1);
    do_reset();
    repeat (TIMEOUT - 1) cycle(0, 0);
    cycle(1, 100);
    check_eq("to_accept", 32'(fault), 0);
    repeat (5) cycle(0, 0);
    check_eq("to_after", 32'(fault), 0);

    // Randomized traffic against the model.
    for (int it = 0; it < 3000; it++) begin
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        do_reset();
      end else if (r < 5) begin
        repeat (TIMEOUT + 3) cycle(0, 0);
      end else begin
        v = ($urandom_range(0, 2) != 0);
        p = int'($urandom_range(0, 99));
        base = (((it / 150) % 2) != 0) ? 170 : 100;
        if (p < 2) d = 0;
        else if (p < 4) d = MAXCODE;
        else d = base + int'($urandom_range(0, 40)) - 20;
        cycle(v, d);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
